// File: rtl/fc_layer_if.sv
// fc_layer_if: start/busy/done handshake plus the weight-memory read port of fc_layer.
interface fc_layer_if #(
    parameter int LANES = 8,
    parameter int AW    = 15
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  w_ren;
    logic [AW-1:0]         w_addr;
    logic [LANES-1:0][7:0] w_rdata;
    modport master (output start, w_rdata, input busy, done, w_ren, w_addr);
    modport slave  (input start, w_rdata, output busy, done, w_ren, w_addr);
endinterface

// File: rtl/fc_layer.sv
// fc_layer: fully connected layer, LANES int8-weight MACs per cycle over 32-bit inputs,
// bias preload, arithmetic shift, 32-bit saturation and optional ReLU per neuron.
module fc_layer #(
    parameter int IN_LEN    = 1568,
    parameter int OUT_LEN   = 128,
    parameter int LANES     = 8,
    parameter int ACC_W     = 48,
    parameter int OUT_SHIFT = 0,
    parameter int RELU_EN   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    fc_layer_if.slave          bus,
    input  logic signed [31:0] in_data   [0:IN_LEN-1],
    input  logic signed [31:0] biases    [0:OUT_LEN-1],
    output logic signed [31:0] fc_output [0:OUT_LEN-1]
);
    localparam int CHUNKS = IN_LEN / LANES;
    localparam int AW     = (OUT_LEN * CHUNKS > 1) ? $clog2(OUT_LEN * CHUNKS) : 1;
    localparam int NW     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int CW     = $clog2(CHUNKS + 1);
    localparam int IW     = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    if (IN_LEN % LANES != 0) $error("IN_LEN must be a multiple of LANES");
    if (ACC_W < 40) $error("ACC_W must be at least 40");

    typedef enum logic [2:0] {IDLE, LOAD_BIAS, ACCUM, DRAIN, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NW-1:0]           neuron_q, neuron_d;
    logic [CW-1:0]           chunk_q, chunk_d, rd_chunk;
    logic [AW-1:0]           addr_q, addr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, mac_sum, acc_sh;
    logic signed [31:0]      out_q [0:OUT_LEN-1];
    logic signed [31:0]      out_d [0:OUT_LEN-1];
    logic signed [39:0]      prod;
    logic signed [31:0]      y_sat, y;
    logic [IW-1:0]           idx;

    // Data returning this cycle belongs to the chunk issued one cycle earlier.
    always_comb begin
        rd_chunk = (chunk_q == '0) ? '0 : chunk_q - 1'b1;
        mac_sum  = '0;
        prod     = '0;
        idx      = '0;
        for (int k = 0; k < LANES; k++) begin
            idx     = IW'(rd_chunk * LANES + k);
            prod    = 40'(in_data[idx]) * 40'($signed(bus.w_rdata[k]));
            mac_sum = mac_sum + ACC_W'(prod);
        end
    end

    always_comb begin
        acc_sh = acc_q >>> OUT_SHIFT;
        y_sat  = (acc_sh > MAX_V) ? 32'sh7fffffff : (acc_sh < MIN_V) ? 32'sh80000000 : acc_sh[31:0];
        y      = (RELU_EN != 0 && y_sat[31]) ? '0 : y_sat;
    end

    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        chunk_d  = chunk_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        out_d    = out_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = LOAD_BIAS;
                neuron_d = '0;
                addr_d   = '0;
            end
            LOAD_BIAS: begin
                acc_d   = ACC_W'(biases[neuron_q]);
                chunk_d = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                chunk_d = chunk_q + 1'b1;
                addr_d  = addr_q + 1'b1;
                acc_d   = (chunk_q != '0) ? acc_q + mac_sum : acc_q;
                state_d = (chunk_q == CW'(CHUNKS - 1)) ? DRAIN : ACCUM;
            end
            DRAIN: begin
                acc_d   = acc_q + mac_sum;
                state_d = WRITE;
            end
            WRITE: begin
                out_d[neuron_q] = y;
                state_d  = (neuron_q == NW'(OUT_LEN - 1)) ? DONE : LOAD_BIAS;
                neuron_d = (neuron_q == NW'(OUT_LEN - 1)) ? neuron_q : neuron_q + 1'b1;
            end
            DONE: state_d = bus.start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            neuron_q <= '0;
            chunk_q  <= '0;
            addr_q   <= '0;
            acc_q    <= '0;
            for (int i = 0; i < OUT_LEN; i++) out_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
            chunk_q  <= chunk_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
        end
    end

    assign bus.busy   = state_q != IDLE && state_q != DONE;
    assign bus.done   = state_q == DONE;
    assign bus.w_ren  = state_q == ACCUM;
    assign bus.w_addr = (state_q == ACCUM) ? addr_q : '0;
    assign fc_output  = out_q;
endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: three lockstep fc_layer variants (ReLU, linear, linear with shift 2)
// checked against a plain-arithmetic dot-product reference.
module tb_fc_layer;
    localparam int IN_LEN = 16, OUT_LEN = 2, LANES = 4, ACC_W = 48;
    localparam int CHUNKS = IN_LEN / LANES, AW = 3;
    localparam longint MAXV = 64'sd2147483647, MINV = -64'sd2147483648;

    logic clk = 0, reset_n = 1, start = 0;
    logic signed [31:0] in_data [0:IN_LEN-1];
    logic signed [31:0] biases  [0:OUT_LEN-1];
    logic signed [31:0] o0 [0:OUT_LEN-1];
    logic signed [31:0] o1 [0:OUT_LEN-1];
    logic signed [31:0] o2 [0:OUT_LEN-1];
    logic [LANES-1:0][7:0] wmem [0:OUT_LEN*CHUNKS-1];
    int n_chk = 0, n_fail = 0;
    int addrs[$];

    fc_layer_if #(.LANES(LANES), .AW(AW)) b0 ();
    fc_layer_if #(.LANES(LANES), .AW(AW)) b1 ();
    fc_layer_if #(.LANES(LANES), .AW(AW)) b2 ();

    fc_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .ACC_W(ACC_W), .OUT_SHIFT(0), .RELU_EN(1))
        u0 (.clk(clk), .reset_n(reset_n), .bus(b0), .in_data(in_data), .biases(biases), .fc_output(o0));
    fc_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .ACC_W(ACC_W), .OUT_SHIFT(0), .RELU_EN(0))
        u1 (.clk(clk), .reset_n(reset_n), .bus(b1), .in_data(in_data), .biases(biases), .fc_output(o1));
    fc_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .ACC_W(ACC_W), .OUT_SHIFT(2), .RELU_EN(0))
        u2 (.clk(clk), .reset_n(reset_n), .bus(b2), .in_data(in_data), .biases(biases), .fc_output(o2));

    assign b0.start = start;
    assign b1.start = start;
    assign b2.start = start;

    always #5 clk = ~clk;

    // Weight memory with one cycle of read latency per instance.
    always @(posedge clk) if (b0.w_ren) b0.w_rdata <= wmem[b0.w_addr];
    always @(posedge clk) if (b1.w_ren) b1.w_rdata <= wmem[b1.w_addr];
    always @(posedge clk) if (b2.w_ren) b2.w_rdata <= wmem[b2.w_addr];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] model(input int n, input int sh, input bit relu);
        longint acc = longint'(biases[n]);
        for (int j = 0; j < IN_LEN; j++)
            acc += longint'(in_data[j]) * longint'($signed(wmem[n*CHUNKS + j/LANES][j%LANES]));
        acc = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
        acc = acc >>> sh;
        acc = (acc > MAXV) ? MAXV : (acc < MINV) ? MINV : acc;
        if (relu && acc < 0) acc = 0;
        return 32'(acc);
    endfunction

    task automatic fill(input logic signed [31:0] x, input logic [7:0] w,
                        input logic signed [31:0] bz, input logic signed [31:0] bo);
        for (int i = 0; i < IN_LEN; i++) in_data[i] = x;
        for (int a = 0; a < OUT_LEN*CHUNKS; a++) wmem[a] = {LANES{w}};
        biases[0] = bz;
        biases[1] = bo;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < IN_LEN; i++) in_data[i] = $urandom();
        for (int a = 0; a < OUT_LEN*CHUNKS; a++) wmem[a] = $urandom();
        for (int n = 0; n < OUT_LEN; n++) biases[n] = $urandom();
    endtask

    task automatic run(input string tag);
        int cyc = 0;
        addrs.delete();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy"}, b0.busy, 1);
        while (!b0.done && cyc < 200) begin
            if (b0.w_ren) addrs.push_back(int'(b0.w_addr));
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, cyc, OUT_LEN*(CHUNKS+3));
        chk({tag, "_nreads"}, addrs.size(), OUT_LEN*CHUNKS);
        for (int i = 0; i < addrs.size(); i++) chk($sformatf("%s_addr%0d", tag, i), addrs[i], i);
    endtask

    task automatic check_all(input string tag);
        for (int n = 0; n < OUT_LEN; n++) begin
            chk($sformatf("%s_relu_n%0d", tag, n), o0[n], model(n, 0, 1));
            chk($sformatf("%s_lin_n%0d", tag, n), o1[n], model(n, 0, 0));
            chk($sformatf("%s_shr_n%0d", tag, n), o2[n], model(n, 2, 0));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        fill(0, 8'd0, 0, 0);
        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", b0.busy, 0);
        chk("rst_done", b0.done, 0);
        chk("rst_wren", b0.w_ren, 0);
        chk("rst_waddr", b0.w_addr, 0);
        for (int n = 0; n < OUT_LEN; n++) chk($sformatf("rst_out%0d", n), o1[n], 0);
        reset_n = 1;
        @(negedge clk);

        fill(1, 8'd2, 5, -100);
        run("basic");
        chk("basic_relu_n0", o0[0], 37);
        chk("basic_relu_n1", o0[1], 0);
        chk("basic_lin_n0", o1[0], 37);
        chk("basic_lin_n1", o1[1], -68);
        chk("basic_shr_n0", o2[0], 9);
        chk("basic_shr_n1", o2[1], -17);
        check_all("basic");

        repeat (6) @(negedge clk);
        chk("hold_done", b0.done, 1);
        chk("hold_busy", b0.busy, 0);
        start = 0;
        run("rerun");
        chk("rerun_lin_n1", o1[1], -68);
        check_all("rerun");
        idle();

        fill(127, 8'd127, 32'sh7fffffff, 32'sh7fffffff);
        run("satpos");
        chk("satpos_lin_n0", o1[0], MAXV);
        chk("satpos_relu_n1", o0[1], MAXV);
        check_all("satpos");
        idle();

        fill(127, 8'h81, 32'sh80000000, 32'sh80000000);
        run("satneg");
        chk("satneg_lin_n0", o1[0], MINV);
        chk("satneg_relu_n0", o0[0], 0);
        check_all("satneg");
        idle();

        fill(0, 8'd0, 32'sh7fffffff, 32'sh80000000);
        in_data[0] = 1;
        wmem[0] = 32'h0000_0001;
        wmem[CHUNKS] = 32'h0000_00ff;
        run("edge");
        chk("edge_lin_n0", o1[0], MAXV);
        chk("edge_lin_n1", o1[1], MINV);
        chk("edge_relu_n1", o0[1], 0);
        check_all("edge");
        idle();

        fill(0, 8'd3, -7, 7);
        run("shift");
        chk("shift_shr_n0", o2[0], -2);
        chk("shift_shr_n1", o2[1], 1);
        check_all("shift");
        idle();

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            run($sformatf("rand%0d", r));
            check_all($sformatf("rand%0d", r));
            idle();
        end

        fill_rand();
        @(negedge clk);
        start = 1;
        cyc = 0;
        while (!(b0.w_ren && b0.w_addr >= 3'(CHUNKS)) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reached", cyc < 100, 1);
        #1 reset_n = 0;
        #1;
        chk("midrst_busy", b0.busy, 0);
        chk("midrst_done", b0.done, 0);
        chk("midrst_wren", b0.w_ren, 0);
        chk("midrst_waddr", b0.w_addr, 0);
        for (int n = 0; n < OUT_LEN; n++) begin
            chk($sformatf("midrst_relu%0d", n), o0[n], 0);
            chk($sformatf("midrst_lin%0d", n), o1[n], 0);
            chk($sformatf("midrst_shr%0d", n), o2[n], 0);
        end
        start = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (4) @(negedge clk);
        chk("midrst_no_resume", b0.busy, 0);
        chk("midrst_wren_idle", b0.w_ren, 0);
        run("after_rst");
        check_all("after_rst");
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
